// File: rtl/dp_uram_pipe.sv
// Simple dual-port URAM buffer: byte-enabled write on port A, pipelined read on port B.
// Optional per-byte even parity is compiled in with macro DP_URAM_PARITY_EN.
module dp_uram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 3,
    parameter int WR_BYPASS    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_a,
    input  logic [DATA_WIDTH/8-1:0] wr_be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    input  logic                    err_inject_a,
    input  logic                    rd_en_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    output logic [DATA_WIDTH-1:0]   dout_b,
    output logic                    dout_valid_b,
    output logic                    parity_err_b
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef DP_URAM_PARITY_EN
    localparam int ARR_W = DATA_WIDTH + NB;
`else
    localparam int ARR_W = DATA_WIDTH;
`endif

    logic [ARR_W-1:0] mem_q [DEPTH];

    logic [ARR_W-1:0] wr_word;
    logic [ARR_W-1:0] wr_mask;
    logic [ARR_W-1:0] rd_word_d;
    logic             perr_d;

    logic [READ_LATENCY-1:0][ARR_W-1:0] data_q;
    logic [READ_LATENCY-1:0]            vld_q;
    logic [DATA_WIDTH-1:0]              dout_q;
    logic                               dv_q;
    logic                               perr_q;

    // Stored word image and lane mask for the incoming write (data plus parity lanes).
    always_comb begin
        wr_word = '0;
        wr_mask = '0;
        wr_word[DATA_WIDTH-1:0] = din_a;
        for (int i = 0; i < NB; i++) begin
            wr_mask[8*i +: 8] = {8{wr_be_a[i]}};
`ifdef DP_URAM_PARITY_EN
            wr_word[DATA_WIDTH+i] = (^din_a[8*i +: 8]) ^ err_inject_a;
            wr_mask[DATA_WIDTH+i] = wr_be_a[i];
`endif
        end
    end

`ifndef DP_URAM_PARITY_EN
    logic unused_inj;
    assign unused_inj = err_inject_a;
`endif

    always_ff @(posedge clk) begin
        if (!rst && wr_en_a)
            mem_q[addr_a] <= (mem_q[addr_a] & ~wr_mask) | (wr_word & wr_mask);
    end

    // Array read is read-first; the bypass merges this cycle's enabled bytes over the old word.
    always_comb begin
        rd_word_d = mem_q[addr_b];
        if (WR_BYPASS != 0 && wr_en_a && addr_a == addr_b)
            rd_word_d = (rd_word_d & ~wr_mask) | (wr_word & wr_mask);
    end

    always_ff @(posedge clk) begin
        if (rd_en_b && !rst)
            data_q[0] <= rd_word_d;
        for (int j = 1; j < READ_LATENCY; j++)
            data_q[j] <= data_q[j-1];
    end

    always_comb begin
        perr_d = 1'b0;
`ifdef DP_URAM_PARITY_EN
        for (int i = 0; i < NB; i++)
            perr_d = perr_d | ((^data_q[READ_LATENCY-1][8*i +: 8]) ^ data_q[READ_LATENCY-1][DATA_WIDTH+i]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            dv_q   <= 1'b0;
            dout_q <= '0;
            perr_q <= 1'b0;
        end else begin
            vld_q[0] <= rd_en_b;
            for (int j = 1; j < READ_LATENCY; j++)
                vld_q[j] <= vld_q[j-1];
            dv_q <= vld_q[READ_LATENCY-1];
            if (vld_q[READ_LATENCY-1]) begin
                dout_q <= data_q[READ_LATENCY-1][DATA_WIDTH-1:0];
                perr_q <= perr_d;
            end else begin
                perr_q <= 1'b0;
            end
        end
    end

    assign dout_b       = dout_q;
    assign dout_valid_b = dv_q;
    assign parity_err_b = perr_q;

endmodule

// File: tb/tb_dp_uram_pipe.sv
// Directed bench for dp_uram_pipe: vector table for streaming plus hand sequences for
// reset, byte enables, collision, mid-flight reset and (with DP_URAM_PARITY_EN) parity.
module tb_dp_uram_pipe;

    localparam int DW  = 32;
    localparam int AW  = 14;
    localparam int BYP = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en_a;
    logic [3:0]    wr_be_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          err_inject_a;
    logic          rd_en_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] dout_b;
    logic          dout_valid_b;
    logic          parity_err_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dp_uram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .WR_BYPASS(BYP)) dut (
        .clk(clk), .rst(rst),
        .wr_en_a(wr_en_a), .wr_be_a(wr_be_a), .addr_a(addr_a), .din_a(din_a),
        .err_inject_a(err_inject_a),
        .rd_en_b(rd_en_b), .addr_b(addr_b),
        .dout_b(dout_b), .dout_valid_b(dout_valid_b), .parity_err_b(parity_err_b)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic          exp_v;
        logic          chk_d;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t tbl [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en_a = 1'b0; wr_be_a = 4'h0; addr_a = '0; din_a = '0; err_inject_a = 1'b0;
        rd_en_b = 1'b0; addr_b = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] be, input logic inj);
        wr_en_a = 1'b1; addr_a = a; din_a = d; wr_be_a = be; err_inject_a = inj;
        tick();
        idle_inputs();
    endtask

    // Watches six edges after the request edge; expects exactly one pulse on the third.
    task automatic observe(input logic [DW-1:0] exp, input logic exp_pe, input string nm);
        int lat = 0;
        int pulses = 0;
        logic [DW-1:0] d = '0;
        logic pe = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (dout_valid_b === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = c; d = dout_b; pe = parity_err_b;
                end
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'd3);
        chk({nm, " pulses"}, 32'(pulses), 32'd1);
        chk({nm, " data"}, d, exp);
        chk({nm, " parity"}, 32'(pe), 32'(exp_pe));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input logic exp_pe, input string nm);
        rd_en_b = 1'b1; addr_b = a;
        tick();
        idle_inputs();
        observe(exp, exp_pe, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Streaming table: preload addr*3, then 8 back-to-back reads; row 9 rewrites
        // addr 0 after its request edge, which must not affect the returned data.
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{we: 1'b0, wa: '0, wd: '0, re: 1'b0, ra: '0,
                       exp_v: 1'b0, chk_d: 1'b0, exp_d: '0};
            if (i < 8) begin
                tbl[i].we = 1'b1; tbl[i].wa = AW'(i); tbl[i].wd = 32'(i * 3);
            end
            if (i >= 8 && i < 16) begin
                tbl[i].re = 1'b1; tbl[i].ra = AW'(i - 8);
            end
            if (i >= 11 && i <= 18) begin
                tbl[i].exp_v = 1'b1; tbl[i].chk_d = 1'b1; tbl[i].exp_d = 32'((i - 11) * 3);
            end
        end
        tbl[9].we = 1'b1; tbl[9].wa = '0; tbl[9].wd = 32'hFFFF_FFFF;
        tbl[19].chk_d = 1'b1; tbl[19].exp_d = 32'd21;

        idle_inputs();
        rst = 1'b1;
        rd_en_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset valid", 32'(dout_valid_b), 32'd0);
            chk("reset dout", dout_b, 32'd0);
            chk("reset perr", 32'(parity_err_b), 32'd0);
        end
        // Request held on the first edge after release: quiet for 3 cycles, pulse on the 4th.
        rst = 1'b0;
        tick();
        chk("post-reset valid c0", 32'(dout_valid_b), 32'd0);
        rd_en_b = 1'b0;
        tick();
        chk("post-reset valid c1", 32'(dout_valid_b), 32'd0);
        tick();
        chk("post-reset valid c2", 32'(dout_valid_b), 32'd0);
        tick();
        chk("post-reset valid c3", 32'(dout_valid_b), 32'd1);
        tick();
        chk("post-reset valid c4", 32'(dout_valid_b), 32'd0);

        do_write(14'h010, 32'hA5A5_A5A5, 4'hF, 1'b0);
        tick();
        do_read(14'h010, 32'hA5A5_A5A5, 1'b0, "full write");

        do_write(14'h010, 32'h1122_3344, 4'b0101, 1'b0);
        do_read(14'h010, 32'hA522_A544, 1'b0, "byte enable");

        do_write(14'h020, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wr_en_a = 1'b1; addr_a = 14'h020; din_a = 32'h0000_0001; wr_be_a = 4'h1;
        rd_en_b = 1'b1; addr_b = 14'h020;
        tick();
        idle_inputs();
        observe((BYP != 0) ? 32'hDEAD_BE01 : 32'hDEAD_BEEF, 1'b0, "collision");
        do_read(14'h020, 32'hDEAD_BE01, 1'b0, "after collision");

        for (int i = 0; i < 20; i++) begin
            wr_en_a = tbl[i].we; wr_be_a = 4'hF; addr_a = tbl[i].wa; din_a = tbl[i].wd;
            rd_en_b = tbl[i].re; addr_b = tbl[i].ra;
            tick();
            chk($sformatf("stream row %0d valid", i), 32'(dout_valid_b), 32'(tbl[i].exp_v));
            if (tbl[i].chk_d)
                chk($sformatf("stream row %0d data", i), dout_b, tbl[i].exp_d);
        end
        idle_inputs();

        rd_en_b = 1'b1; addr_b = 14'h010;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dout_valid_b === 1'b1) pulses++;
        end
        chk("midflight reset pulses", 32'(pulses), 32'd0);
        chk("midflight reset dout", dout_b, 32'd0);

`ifdef DP_URAM_PARITY_EN
        do_write(14'h030, 32'h1234_5678, 4'hF, 1'b1);
        do_read(14'h030, 32'h1234_5678, 1'b1, "parity inject");
        do_write(14'h030, 32'h1234_5678, 4'hF, 1'b0);
        do_read(14'h030, 32'h1234_5678, 1'b0, "parity clean");
`else
        do_write(14'h030, 32'h1234_5678, 4'hF, 1'b1);
        do_read(14'h030, 32'h1234_5678, 1'b0, "inject ignored");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
